// File: rtl/mem_dport_responder_pkg.sv
// Shared types for the MEM-stage data-memory responder: word/mask types,
// the write-buffer entry layout and the word-address helper used for
// load/store hazard matching.
package mem_dport_responder_pkg;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef struct packed {
      lc3b_word      addr;
      lc3b_mem_wmask wmask;
      lc3b_word      wdata;
   } wb_entry_t;

   // Loads always fetch the whole word; lane selection happens upstream.
   localparam lc3b_mem_wmask WMASK_FULL = 2'b11;

   // Word address of a byte address (drops the lane bit).
   function automatic logic [14:0] word_addr(input lc3b_word addr);
      return addr[15:1];
   endfunction

endpackage

// File: rtl/mem_dport_responder_write_buffer.sv
// Posted-store FIFO with a parallel word-address compare across all valid
// entries. Pointers wrap modulo WB_DEPTH (power of two). Push and pop in the
// same cycle leave the count unchanged while both pointers advance.
module mem_write_buffer
   import mem_dport_responder_pkg::*;
#(
   parameter int WB_DEPTH = 2
)
(
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  wb_entry_t                  push_entry,
   input  logic                       pop,
   output wb_entry_t                  head,
   output logic [$clog2(WB_DEPTH):0]  count,
   input  logic [14:0]                match_addr,
   output logic                       hit
);

   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t            entry_r [WB_DEPTH];
   logic [PTR_W-1:0]     rd_ptr_r;
   logic [PTR_W-1:0]     wr_ptr_r;
   logic [CNT_W-1:0]     count_r;
   logic                 push_s;
   logic                 pop_s;
   logic [WB_DEPTH-1:0]  valid_s;

   // Guard against popping an empty buffer or pushing into a full one
   // (a push into a full buffer is only legal alongside a pop).
   assign pop_s  = pop && (count_r != CNT_W'(0));
   assign push_s = push && ((count_r != CNT_W'(WB_DEPTH)) || pop_s);

   assign head  = entry_r[rd_ptr_r];
   assign count = count_r;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_r <= PTR_W'(0);
         wr_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; only the slot under the write pointer changes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < WB_DEPTH; i++) begin
            entry_r[i] <= '0;
         end
      end else begin
         if (push_s) begin
            entry_r[wr_ptr_r] <= push_entry;
         end
      end
   end

   // An entry is live when its distance from the read pointer is below the
   // count; any live entry on the same word raises hit.
   always_comb begin
      hit     = 1'b0;
      valid_s = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         valid_s[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr_r)} < count_r);
         hit = hit | (valid_s[i] && (word_addr(entry_r[i].addr) == match_addr));
      end
   end

endmodule

// File: rtl/mem_dport_responder.sv
// Responder for the MEM-stage data-memory handshake. Stores are posted into
// mem_write_buffer and acknowledged after one cycle; loads go to the lower
// level ahead of buffered stores unless a buffered store hits the same word,
// in which case the buffer drains until the hazard clears.
module mem_dport_responder
   import mem_dport_responder_pkg::*;
#(
   parameter int WB_DEPTH = 2
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_wmask,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   output logic        mem_resp,
   output logic [15:0] mem_rdata,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic [1:0]  pmem_wmask,
   output logic [15:0] pmem_address,
   output logic [15:0] pmem_wdata,
   input  logic        pmem_resp,
   input  logic [15:0] pmem_rdata,
   output logic        wb_empty
);

   localparam int CNT_W = $clog2(WB_DEPTH) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_DONE = 2'd2,
      WR_WAIT = 2'd3
   } state_t;

   state_t         state_r, state_next_s;
   logic           mem_resp_r, mem_resp_next_s;
   lc3b_word       rdata_r, rdata_next_s;
   logic           pmem_read_r, pmem_read_next_s;
   logic           pmem_write_r, pmem_write_next_s;
   lc3b_mem_wmask  pmem_wmask_r, pmem_wmask_next_s;
   lc3b_word       pmem_address_r, pmem_address_next_s;
   lc3b_word       pmem_wdata_r, pmem_wdata_next_s;

   wb_entry_t         push_entry_s;
   wb_entry_t         head_s;
   logic [CNT_W-1:0]  wb_count_s;
   logic              hit_s;
   logic              push_s;
   logic              pop_s;
   logic              wb_full_s;
   logic              wb_nonempty_s;

   assign push_entry_s  = '{addr: mem_address, wmask: mem_wmask, wdata: mem_wdata};
   assign wb_full_s     = (wb_count_s == CNT_W'(WB_DEPTH));
   assign wb_nonempty_s = (wb_count_s != CNT_W'(0));

   mem_write_buffer #(
      .WB_DEPTH (WB_DEPTH)
   ) u_wb (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .head       (head_s),
      .count      (wb_count_s),
      .match_addr (word_addr(mem_address)),
      .hit        (hit_s)
   );

   // Next-state, buffer control and next values of the registered outputs.
   always_comb begin
      state_next_s        = state_r;
      push_s              = 1'b0;
      pop_s               = 1'b0;
      mem_resp_next_s     = 1'b0;
      rdata_next_s        = rdata_r;
      pmem_read_next_s    = pmem_read_r;
      pmem_write_next_s   = pmem_write_r;
      pmem_wmask_next_s   = pmem_wmask_r;
      pmem_address_next_s = pmem_address_r;
      pmem_wdata_next_s   = pmem_wdata_r;
      case (state_r)
         IDLE: begin
            if (mem_resp_r) begin
               // The MEM stage is still showing the request just answered;
               // wait one cycle so a following load keeps priority over drain.
               state_next_s = IDLE;
            end else if (mem_read && !hit_s) begin
               state_next_s        = RD_WAIT;
               pmem_read_next_s    = 1'b1;
               pmem_address_next_s = mem_address;
               pmem_wmask_next_s   = WMASK_FULL;
               pmem_wdata_next_s   = 16'h0000;
            end else if (mem_write && !mem_read && !wb_full_s) begin
               push_s          = 1'b1;
               mem_resp_next_s = 1'b1;
            end else if (wb_nonempty_s) begin
               // Covers idle drain, full-buffer stores and same-word loads.
               state_next_s        = WR_WAIT;
               pmem_write_next_s   = 1'b1;
               pmem_address_next_s = head_s.addr;
               pmem_wmask_next_s   = head_s.wmask;
               pmem_wdata_next_s   = head_s.wdata;
            end else begin
               state_next_s = IDLE;
            end
         end
         RD_WAIT: begin
            if (pmem_resp) begin
               state_next_s     = RD_DONE;
               rdata_next_s     = pmem_rdata;
               pmem_read_next_s = 1'b0;
               mem_resp_next_s  = 1'b1;
            end else begin
               state_next_s = RD_WAIT;
            end
         end
         RD_DONE: begin
            state_next_s = IDLE;
         end
         WR_WAIT: begin
            if (pmem_resp) begin
               state_next_s      = IDLE;
               pop_s             = 1'b1;
               pmem_write_next_s = 1'b0;
            end else begin
               state_next_s = WR_WAIT;
            end
         end
         default: begin
            state_next_s      = IDLE;
            pmem_read_next_s  = 1'b0;
            pmem_write_next_s = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Registered handshake outputs; reset abandons any lower-level access.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_resp_r     <= 1'b0;
         rdata_r        <= 16'h0000;
         pmem_read_r    <= 1'b0;
         pmem_write_r   <= 1'b0;
         pmem_wmask_r   <= 2'b00;
         pmem_address_r <= 16'h0000;
         pmem_wdata_r   <= 16'h0000;
      end else begin
         mem_resp_r     <= mem_resp_next_s;
         rdata_r        <= rdata_next_s;
         pmem_read_r    <= pmem_read_next_s;
         pmem_write_r   <= pmem_write_next_s;
         pmem_wmask_r   <= pmem_wmask_next_s;
         pmem_address_r <= pmem_address_next_s;
         pmem_wdata_r   <= pmem_wdata_next_s;
      end
   end

   assign mem_resp     = mem_resp_r;
   assign mem_rdata    = rdata_r;
   assign pmem_read    = pmem_read_r;
   assign pmem_write   = pmem_write_r;
   assign pmem_wmask   = pmem_wmask_r;
   assign pmem_address = pmem_address_r;
   assign pmem_wdata   = pmem_wdata_r;
   assign wb_empty     = (wb_count_s == CNT_W'(0));

endmodule

// File: tb/tb_mem_dport_responder.sv
// Bench for mem_dport_responder: a program-order reference memory predicts
// load data, a queue predicts lower-level writes, and a latency-programmable
// lower-level model answers pmem requests.
module tb_mem_dport_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_read, mem_write;
   logic [1:0]  mem_wmask;
   logic [15:0] mem_address, mem_wdata;
   logic        mem_resp;
   logic [15:0] mem_rdata;
   logic        pmem_read, pmem_write;
   logic [1:0]  pmem_wmask;
   logic [15:0] pmem_address, pmem_wdata;
   logic        pmem_resp;
   logic [15:0] pmem_rdata;
   logic        wb_empty;

   logic        model_resp, man_resp;
   logic [15:0] model_rdata, man_rdata;

   assign pmem_resp  = model_resp | man_resp;
   assign pmem_rdata = man_resp ? man_rdata : model_rdata;

   mem_dport_responder #(.WB_DEPTH(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
      .wb_empty(wb_empty)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Reference (program order) and lower-level memories, keyed by word address.
   logic [15:0] ref_mem [int];
   logic [15:0] low_mem [int];

   function automatic logic [15:0] init_word(input int wa);
      return 16'(wa) ^ 16'h5A3C;
   endfunction

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] m);
      logic [15:0] r;
      r = old;
      if (m[1]) r[15:8] = d[15:8];
      if (m[0]) r[7:0]  = d[7:0];
      return r;
   endfunction

   function automatic logic [15:0] read_ref(input int wa);
      return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
   endfunction

   function automatic logic [15:0] read_low(input int wa);
      return low_mem.exists(wa) ? low_mem[wa] : init_word(wa);
   endfunction

   typedef struct packed {
      logic [15:0] addr;
      logic [1:0]  mask;
      logic [15:0] data;
   } wr_t;

   wr_t         exp_wr [$];
   logic [15:0] exp_rd [$];

   // Lower-level model state
   int          lat_cfg = 2;
   bit          model_en = 1'b1;
   int          wr_done = 0;
   int          wr_done_at_rd = 0;
   logic [15:0] last_rd_addr = 16'h0000;
   int          rd_txn = 0;

   // Lower-level model: responds lat_cfg cycles after a request first appears.
   initial begin
      bit  busy;
      bit  is_wr;
      int  rem;
      wr_t e;
      busy = 1'b0; is_wr = 1'b0; rem = 0;
      model_resp = 1'b0; model_rdata = 16'h0000;
      forever begin
         @(posedge clk); #1;
         model_resp = 1'b0;
         if (!reset_n) begin
            busy = 1'b0;
         end else if (busy) begin
            rem--;
            if (rem == 0) begin
               busy = 1'b0;
               model_resp = 1'b1;
               if (is_wr) begin
                  if (exp_wr.size() == 0) begin
                     fail_now("unexpected_pmem_write");
                  end else begin
                     e = exp_wr.pop_front();
                     check("pmem_write_fields", 64'({pmem_address, pmem_wmask, pmem_wdata}),
                           64'({e.addr, e.mask, e.data}));
                  end
                  low_mem[int'(pmem_address[15:1])] =
                     merge(read_low(int'(pmem_address[15:1])), pmem_wdata, pmem_wmask);
                  wr_done++;
               end else begin
                  model_rdata = read_low(int'(pmem_address[15:1]));
               end
            end
         end else if (model_en && (pmem_read || pmem_write)) begin
            busy  = 1'b1;
            rem   = lat_cfg;
            is_wr = pmem_write;
            if (pmem_read) begin
               last_rd_addr  = pmem_address;
               wr_done_at_rd = wr_done;
            end
         end
      end
   end

   // Output monitor: load-data scoreboard, read transaction count, exclusivity.
   initial begin
      logic        prev_rd;
      logic [15:0] e;
      prev_rd = 1'b0;
      forever begin
         @(negedge clk);
         if (pmem_read && !prev_rd) rd_txn++;
         prev_rd = pmem_read;
         if (pmem_read && pmem_write) fail_now("pmem_read_write_both_high");
         if (mem_resp && mem_read) begin
            if (exp_rd.size() == 0) begin
               fail_now("unexpected_load_resp");
            end else begin
               e = exp_rd.pop_front();
               check("mem_rdata", 64'(mem_rdata), 64'(e));
            end
         end
      end
   end

   task automatic sync();
      @(posedge clk); #1;
   endtask

   // Issue one request (0=read, 1=write, 2=both); n = cycles to mem_resp.
   task automatic do_req(input int rw, input logic [15:0] addr, input logic [1:0] mask,
                         input logic [15:0] data, output int n);
      mem_address = addr; mem_wmask = mask; mem_wdata = data;
      mem_read  = (rw != 1);
      mem_write = (rw != 0);
      if (rw == 1) begin
         exp_wr.push_back('{addr, mask, data});
         ref_mem[int'(addr[15:1])] = merge(read_ref(int'(addr[15:1])), data, mask);
      end else begin
         exp_rd.push_back(read_ref(int'(addr[15:1])));
      end
      n = -1;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_resp && n < 200);
      if (!mem_resp) fail_now("mem_resp_timeout");
      sync();
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic wait_drained();
      int k;
      k = 0;
      while (!(wb_empty && !pmem_write && !pmem_read) && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (k >= 300) fail_now("drain_timeout");
      sync();
   endtask

   typedef struct {
      int          rw;
      logic [15:0] addr;
      logic [1:0]  mask;
      logic [15:0] data;
      int          lat;
      int          exp_n;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int n, n3, wr0, r0, key;
      bit saw;

      vecs[0]  = '{1, 16'h3000, 2'b11, 16'h1234, 2, 1};
      vecs[1]  = '{0, 16'h3000, 2'b11, 16'h0000, 1, 3};
      vecs[2]  = '{1, 16'h3001, 2'b10, 16'hCD00, 3, 1};
      vecs[3]  = '{0, 16'h3000, 2'b11, 16'h0000, 4, 6};
      vecs[4]  = '{1, 16'h3000, 2'b01, 16'h0077, 1, 1};
      vecs[5]  = '{0, 16'h3000, 2'b11, 16'h0000, 2, 4};
      vecs[6]  = '{0, 16'h7000, 2'b11, 16'h0000, 3, 5};
      vecs[7]  = '{0, 16'h0000, 2'b11, 16'h0000, 1, 3};
      vecs[8]  = '{1, 16'hFFFE, 2'b11, 16'hA5A5, 1, 1};
      vecs[9]  = '{0, 16'hFFFE, 2'b11, 16'h0000, 2, 4};
      vecs[10] = '{0, 16'hFFFF, 2'b11, 16'h0000, 2, 4};
      vecs[11] = '{2, 16'h3002, 2'b11, 16'h9999, 1, 3};

      ref_mem[int'(16'h3800)] = 16'hBEEF;
      low_mem[int'(16'h3800)] = 16'hBEEF;

      reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      mem_wmask = 2'b00; mem_address = 16'h0000; mem_wdata = 16'h0000;
      man_resp = 1'b0; man_rdata = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      check("reset_mem_resp", 64'(mem_resp), 64'(0));
      check("reset_mem_rdata", 64'(mem_rdata), 64'(0));
      check("reset_pmem_rw", 64'({pmem_read, pmem_write}), 64'(0));
      check("reset_pmem_fields", 64'({pmem_address, pmem_wmask, pmem_wdata}), 64'(0));
      check("reset_wb_empty", 64'(wb_empty), 64'(1));
      reset_n = 1'b1;
      sync();

      // Table-driven single transactions on an idle responder
      for (int i = 0; i < 12; i++) begin
         lat_cfg = vecs[i].lat;
         do_req(vecs[i].rw, vecs[i].addr, vecs[i].mask, vecs[i].data, n);
         check($sformatf("vec%0d_latency", i), 64'(n), 64'(vecs[i].exp_n));
         wait_drained();
      end

      // Full buffer: third store waits for the first drain to pop
      lat_cfg = 5;
      wr0 = wr_done;
      do_req(1, 16'h4000, 2'b11, 16'h4444, n);
      do_req(1, 16'h4002, 2'b11, 16'h4242, n);
      check("full_wb_not_empty", 64'(wb_empty), 64'(0));
      do_req(1, 16'h4004, 2'b11, 16'h4040, n3);
      check("full_third_ack_latency", 64'(n3), 64'(8));
      check("full_one_drain_before_ack", 64'(wr_done - wr0), 64'(1));
      wait_drained();

      // Same-word hazard: buffered STB drains before the load is issued
      lat_cfg = 2;
      wr0 = wr_done;
      do_req(1, 16'h5001, 2'b10, 16'h00AB, n);
      do_req(0, 16'h5000, 2'b11, 16'h0000, n);
      check("hazard_drain_first", 64'(wr_done_at_rd - wr0), 64'(1));
      check("hazard_rd_addr", 64'(last_rd_addr), 64'(16'h5000));
      wait_drained();

      // Different word: load bypasses the buffered store
      lat_cfg = 3;
      wr0 = wr_done;
      do_req(1, 16'h6000, 2'b11, 16'h6060, n);
      do_req(0, 16'h7000, 2'b11, 16'h0000, n);
      check("bypass_latency", 64'(n), 64'(5));
      check("bypass_rd_before_wr", 64'(wr_done_at_rd - wr0), 64'(0));
      wait_drained();
      check("bypass_drained_after", 64'(wr_done - wr0), 64'(1));

      // Held read across the mem_resp cycle: one lower-level read only
      lat_cfg = 2;
      r0 = rd_txn;
      do_req(0, 16'h3000, 2'b11, 16'h0000, n);
      repeat (5) @(negedge clk);
      check("single_rd_txn", 64'(rd_txn - r0), 64'(1));
      sync();

      // Reset during RD_WAIT with a buffered store; late pmem_resp ignored
      model_en = 1'b0;
      do_req(1, 16'h2100, 2'b11, 16'h1111, n);
      mem_address = 16'h2000; mem_wmask = 2'b11; mem_read = 1'b1;
      n = 0;
      while (!pmem_read && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst_pre_pmem_read", 64'(pmem_read), 64'(1));
      check("rst_pre_wb_empty", 64'(wb_empty), 64'(0));
      sync();
      reset_n = 1'b0; mem_read = 1'b0;
      #1;
      check("rst_pmem_read_drop", 64'(pmem_read), 64'(0));
      check("rst_wb_empty", 64'(wb_empty), 64'(1));
      check("rst_mem_resp", 64'(mem_resp), 64'(0));
      sync();
      reset_n = 1'b1; man_rdata = 16'hDEAD; man_resp = 1'b1;
      sync();
      man_resp = 1'b0;
      saw = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (mem_resp || pmem_read || pmem_write) saw = 1'b1;
      end
      check("rst_late_resp_ignored", 64'(saw), 64'(0));
      exp_wr.delete();
      key = int'(16'h1080);
      ref_mem.delete(key);
      model_en = 1'b1;
      sync();

      check("exp_wr_drained", 64'(exp_wr.size()), 64'(0));
      check("exp_rd_drained", 64'(exp_rd.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
